// File: rtl/rect_fill_gen_engine.sv
// Rectangle-fill write-beat generator feeding the memory arbiter.
// Latches geometry and colour on a start strobe, then streams fill beats
// across NUM_CH interleaved colour planes, advancing only on arbiter transfer.
// Build option: RECT_FILL_WORD_MERGE_EN merges all lanes of a word into one
// beat per channel; without it each beat carries a single byte lane.
//
// state | meaning
// IDLE  | waiting for gen_start_strobe; data_gen_is_idle high
// DRIVE | presenting beats; counters step on each transfer
// DONE  | one-cycle gen_done_strobe, then back to IDLE
module rect_fill_gen_engine #(
   parameter int ADDR_W     = 16,
   parameter int DIM_W      = 16,
   parameter int DATA_W     = 32,
   parameter int PIX_W      = 4,
   parameter int NUM_CH     = 3,
   parameter int ROW_STRIDE = 240
) (
   input  logic                    clk,
   input  logic                    rst_,
   input  logic                    gen_start_strobe,
   input  logic [ADDR_W-1:0]       init_addr,
   input  logic [DIM_W-1:0]        cmd_data_hgt,
   input  logic [DIM_W-1:0]        cmd_data_wid,
   input  logic [NUM_CH*PIX_W-1:0] cmd_data_color,
   output logic                    data_gen_is_idle,
   output logic                    gen_done_strobe,
   output logic                    arb_out_rts,
   input  logic                    arb_in_rtr,
   output logic [DATA_W/8-1:0]     arb_out_wben,
   output logic [ADDR_W-1:0]       arb_out_addr,
   output logic [DATA_W-1:0]       arb_out_data,
   output logic                    arb_out_op
);

   localparam int PPL   = 8 / PIX_W;
   localparam int PPW   = DATA_W / PIX_W;
   localparam int LANES = DATA_W / 8;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int COL_W = NUM_CH * PIX_W;
`ifdef RECT_FILL_WORD_MERGE_EN
   localparam bit MERGE = 1'b1;
`else
   localparam bit MERGE = 1'b0;
`endif
   // Pixels covered by one step of the group counter: a byte lane, or a whole word when merging.
   localparam int GRP_PIX = MERGE ? PPW : PPL;

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LANES-1:0]  wben;
      logic [DATA_W-1:0] data;
   } beat_t;

   state_t             state;
   logic [DIM_W-1:0]   hgt_q, wid_q, ngrp_q, row_q, grp_q;
   logic [CH_W-1:0]    ch_q;
   logic [COL_W-1:0]   color_q;
   logic [ADDR_W-1:0]  row_base_q;
   beat_t              beat_q;
   logic               rts_q, done_q;

   logic               xfc, beat_last;
   logic [DIM_W-1:0]   nxt_row, nxt_grp, start_ngrp;
   logic [CH_W-1:0]    nxt_ch;
   logic [ADDR_W-1:0]  nxt_row_base;

   // Build one beat from the row base, pixel-group index and channel.
   // Slots past the rect edge stay 0; in merge mode their lanes are also disabled.
   function automatic beat_t beat_calc(input logic [ADDR_W-1:0] rb, input logic [DIM_W-1:0] g,
                                       input logic [CH_W-1:0] c, input logic [DIM_W-1:0] w,
                                       input logic [COL_W-1:0] colr);
      beat_t            b;
      int               first_col, col, slot;
      logic [PIX_W-1:0] nib;
      b         = '0;
      nib       = PIX_W'(colr >> (int'(c) * PIX_W));
      first_col = int'(g) * GRP_PIX;
      b.addr    = rb + ADDR_W'((first_col / PPW) * NUM_CH) + ADDR_W'(c);
      for (int k = 0; k < GRP_PIX; k++) begin
         col  = first_col + k;
         slot = col % PPW;
         if (col < int'(w)) b.data = b.data | (DATA_W'(nib) << (slot * PIX_W));
         if (!MERGE || col < int'(w)) b.wben = b.wben | (LANES'(1) << (slot / PPL));
      end
      return b;
   endfunction

   // Transfer qualifier, last-beat detect and the counter values after this beat.
   always_comb begin
      xfc          = rts_q & arb_in_rtr;
      start_ngrp   = DIM_W'((int'(cmd_data_wid) + GRP_PIX - 1) / GRP_PIX);
      beat_last    = (row_q == hgt_q - DIM_W'(1)) && (grp_q == ngrp_q - DIM_W'(1)) &&
                     (ch_q == CH_W'(NUM_CH - 1));
      nxt_ch       = ch_q + CH_W'(1);
      nxt_grp      = grp_q;
      nxt_row      = row_q;
      nxt_row_base = row_base_q;
      if (ch_q == CH_W'(NUM_CH - 1)) begin
         nxt_ch = '0;
         if (grp_q == ngrp_q - DIM_W'(1)) begin
            nxt_grp      = '0;
            nxt_row      = row_q + DIM_W'(1);
            nxt_row_base = row_base_q + ADDR_W'(ROW_STRIDE);
         end else begin
            nxt_grp = grp_q + DIM_W'(1);
         end
      end
   end

   // Control FSM with registered beat fields; fields only change on start or transfer.
   always_ff @(posedge clk) begin
      if (!rst_) begin
         state      <= S_IDLE;
         hgt_q      <= '0;
         wid_q      <= '0;
         ngrp_q     <= '0;
         row_q      <= '0;
         grp_q      <= '0;
         ch_q       <= '0;
         color_q    <= '0;
         row_base_q <= '0;
         beat_q     <= '0;
         rts_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done_q <= 1'b0;
               if (gen_start_strobe) begin
                  hgt_q      <= cmd_data_hgt;
                  wid_q      <= cmd_data_wid;
                  color_q    <= cmd_data_color;
                  ngrp_q     <= start_ngrp;
                  row_q      <= '0;
                  grp_q      <= '0;
                  ch_q       <= '0;
                  row_base_q <= init_addr;
                  if (cmd_data_hgt == '0 || cmd_data_wid == '0) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state  <= S_DRIVE;
                     rts_q  <= 1'b1;
                     beat_q <= beat_calc(init_addr, '0, '0, cmd_data_wid, cmd_data_color);
                  end
               end
            end
            S_DRIVE: begin
               if (xfc) begin
                  if (beat_last) begin
                     state  <= S_DONE;
                     rts_q  <= 1'b0;
                     done_q <= 1'b1;
                     beat_q <= '0;
                  end else begin
                     row_q      <= nxt_row;
                     grp_q      <= nxt_grp;
                     ch_q       <= nxt_ch;
                     row_base_q <= nxt_row_base;
                     beat_q     <= beat_calc(nxt_row_base, nxt_grp, nxt_ch, wid_q, color_q);
                  end
               end
            end
            default: begin
               state  <= S_IDLE;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign data_gen_is_idle = (state == S_IDLE);
   assign gen_done_strobe  = done_q;
   assign arb_out_rts      = rts_q;
   assign arb_out_addr     = beat_q.addr;
   assign arb_out_wben     = beat_q.wben;
   assign arb_out_data     = beat_q.data;
   assign arb_out_op       = 1'b0;

endmodule
